// File: rtl/mips32_pkg.sv
// Shared definitions for the 5-stage MIPS32-subset pipeline: opcodes,
// instruction fields, instruction classes and pipeline-latch layouts.
package mips32_pkg;
  localparam int XLEN = 32;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} itype_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    itype_e          itype;
    alu_op_e         alu_op;
    logic            beqz;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic            we;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    itype_e          itype;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic [XLEN-1:0] target;
    logic            cond;
    logic [4:0]      dst;
    logic            we;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    itype_e          itype;
    logic [XLEN-1:0] val;
    logic [4:0]      dst;
    logic            we;
  } mem_wb_t;

  function automatic itype_e decode_type(input logic [5:0] op);
    itype_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = NOP;
    endcase
    return t;
  endfunction

  function automatic alu_op_e alu_sel(input logic [5:0] op);
    alu_op_e a;
    case (op)
      OP_SUB, OP_SUBI: a = ALU_SUB;
      OP_AND:          a = ALU_AND;
      OP_OR:           a = ALU_OR;
      OP_SLT, OP_SLTI: a = ALU_SLT;
      OP_MUL:          a = ALU_MUL;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction
endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU; all arithmetic wraps, SLT is signed.
module mips32_alu
  import mips32_pkg::*;
(
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);
  // select the operation result
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_MUL: y_o = a_i * b_i;
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/pipe_mips32.sv
// 5-stage in-order MIPS32-subset core with unified memory, full forwarding,
// load-use stall, branch resolution in MEM and a sticky halt.
module pipe_mips32
  import mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_W    = 32
) (
  input  logic clk1,
  input  logic rst,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] Mem [0:MEM_DEPTH-1];
  logic [DATA_W-1:0] Reg [0:31];
  logic [DATA_W-1:0] PC;
  logic              HALTED;
  logic              TAKEN_BRANCH;

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, id_rd;
  itype_e            id_type;
  logic              id_use_rs, id_use_rt, load_use, halt_now, freeze, wb_we;
  logic [DATA_W-1:0] ex_a, ex_b, ex_alu_b, ex_y;

  assign halted       = HALTED;
  // HLT in WB stops everything younger from touching state at this very edge
  assign halt_now     = mem_wb_q.valid && (mem_wb_q.itype == HALT);
  assign freeze       = HALTED || halt_now;
  assign wb_we        = mem_wb_q.valid && mem_wb_q.we && (mem_wb_q.dst != 5'd0) && !freeze;
  assign TAKEN_BRANCH = ex_mem_q.valid && (ex_mem_q.itype == BRANCH) && ex_mem_q.cond;

  // IF: fetch the word at PC
  always_comb begin
    if_id_d       = '0;
    if_id_d.valid = 1'b1;
    if_id_d.ir    = Mem[PC[AW-1:0]];
    if_id_d.npc   = PC + 1;
  end

  // ID: decode, register read with WB bypass, load-use detection
  always_comb begin
    id_op     = if_id_q.ir[OP_HI:OP_LO];
    id_rs     = if_id_q.ir[RS_HI:RS_LO];
    id_rt     = if_id_q.ir[RT_HI:RT_LO];
    id_rd     = if_id_q.ir[RD_HI:RD_LO];
    id_type   = decode_type(id_op);
    id_use_rs = id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
    id_use_rt = id_type inside {RR_ALU, STORE};

    id_ex_d        = '0;
    id_ex_d.valid  = if_id_q.valid;
    id_ex_d.itype  = id_type;
    id_ex_d.alu_op = alu_sel(id_op);
    id_ex_d.beqz   = (id_op == OP_BEQZ);
    id_ex_d.npc    = if_id_q.npc;
    id_ex_d.imm    = {{16{if_id_q.ir[IMM_HI]}}, if_id_q.ir[IMM_HI:IMM_LO]};
    id_ex_d.rs     = id_rs;
    id_ex_d.rt     = id_rt;
    id_ex_d.dst    = (id_type == RR_ALU) ? id_rd : id_rt;
    id_ex_d.we     = id_type inside {RR_ALU, RM_ALU, LOAD};
    id_ex_d.a      = (id_rs == 5'd0) ? '0 :
                     (wb_we && mem_wb_q.dst == id_rs) ? mem_wb_q.val : Reg[id_rs];
    id_ex_d.b      = (id_rt == 5'd0) ? '0 :
                     (wb_we && mem_wb_q.dst == id_rt) ? mem_wb_q.val : Reg[id_rt];

    load_use = if_id_q.valid && id_ex_q.valid && (id_ex_q.itype == LOAD) &&
               (id_ex_q.dst != 5'd0) &&
               ((id_use_rs && id_rs == id_ex_q.dst) || (id_use_rt && id_rt == id_ex_q.dst));
  end

  // EX: operand forwarding, nearest producer first
  always_comb begin
    ex_a = id_ex_q.a;
    if (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.dst != 5'd0 && ex_mem_q.dst == id_ex_q.rs)
      ex_a = ex_mem_q.alu;
    else if (mem_wb_q.valid && mem_wb_q.we && mem_wb_q.dst != 5'd0 && mem_wb_q.dst == id_ex_q.rs)
      ex_a = mem_wb_q.val;
    ex_b = id_ex_q.b;
    if (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.dst != 5'd0 && ex_mem_q.dst == id_ex_q.rt)
      ex_b = ex_mem_q.alu;
    else if (mem_wb_q.valid && mem_wb_q.we && mem_wb_q.dst != 5'd0 && mem_wb_q.dst == id_ex_q.rt)
      ex_b = mem_wb_q.val;
    ex_alu_b = (id_ex_q.itype == RR_ALU) ? ex_b : id_ex_q.imm;
  end

  mips32_alu u_alu (
    .op_i (id_ex_q.alu_op),
    .a_i  (ex_a),
    .b_i  (ex_alu_b),
    .y_o  (ex_y)
  );

  // EX -> EX/MEM; the instruction leaving EX dies on a taken branch
  always_comb begin
    ex_mem_d        = '0;
    ex_mem_d.valid  = id_ex_q.valid && !TAKEN_BRANCH;
    ex_mem_d.itype  = id_ex_q.itype;
    ex_mem_d.alu    = ex_y;
    ex_mem_d.sd     = ex_b;
    ex_mem_d.target = id_ex_q.npc + id_ex_q.imm;
    ex_mem_d.cond   = id_ex_q.beqz ? (ex_a == '0) : (ex_a != '0);
    ex_mem_d.dst    = id_ex_q.dst;
    ex_mem_d.we     = id_ex_q.we;
  end

  // MEM -> MEM/WB: loads pick up the memory word, others pass the ALU result
  always_comb begin
    mem_wb_d       = '0;
    mem_wb_d.valid = ex_mem_q.valid;
    mem_wb_d.itype = ex_mem_q.itype;
    mem_wb_d.val   = (ex_mem_q.itype == LOAD) ? Mem[ex_mem_q.alu[AW-1:0]] : ex_mem_q.alu;
    mem_wb_d.dst   = ex_mem_q.dst;
    mem_wb_d.we    = ex_mem_q.we;
  end

  // PC, pipeline latches and halt flag; branch beats stall, halt freezes all
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      PC       <= '0;
      HALTED   <= 1'b0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if (halt_now) HALTED <= 1'b1;
      if (!freeze) begin
        ex_mem_q <= ex_mem_d;
        mem_wb_q <= mem_wb_d;
        if (TAKEN_BRANCH) begin
          PC      <= ex_mem_q.target;
          if_id_q <= '0;
          id_ex_q <= '0;
        end else if (load_use) begin
          id_ex_q <= '0;
        end else begin
          PC      <= PC + 1;
          if_id_q <= if_id_d;
          id_ex_q <= id_ex_d;
        end
      end
    end
  end

  // store commits as it leaves MEM; a same-cycle fetch sees the old word
  always_ff @(posedge clk1) begin
    if (ex_mem_q.valid && ex_mem_q.itype == STORE && !freeze)
      Mem[ex_mem_q.alu[AW-1:0]] <= ex_mem_q.sd;
  end

  // register write-back; R0 is never written
  always_ff @(posedge clk1) begin
    if (wb_we) Reg[mem_wb_q.dst] <= mem_wb_q.val;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program tests for pipe_mips32 with a scoreboard of expected
// architectural results checked once the program halts.
module tb_pipe_mips32;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic halted;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string       tag;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  pipe_mips32 #(.MEM_DEPTH(1024), .DATA_W(32)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b0; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b1; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
      check(e.tag, got, e.val);
    end
  endtask

  // hold reset, clear memory, preload Reg[k]=k
  task automatic begin_test();
    @(negedge clk1);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic release_rst();
    @(negedge clk1);
    rst = 1'b0;
  endtask

  // count edges after reset release until halted is seen
  task automatic run(input string tag, input int exp_edges);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(posedge clk1);
      #1;
      if (halted) begin n = c; done = 1'b1; end
    end
    check(tag, n, exp_edges);
    drain();
  endtask

  task automatic load_prog1();
    dut.Mem[0] = 32'h2801000a;
    dut.Mem[1] = 32'h28020014;
    dut.Mem[2] = 32'h28030019;
    dut.Mem[3] = 32'h0ce77800;
    dut.Mem[4] = 32'h0ce77800;
    dut.Mem[5] = 32'h00222000;
    dut.Mem[6] = 32'h0ce77800;
    dut.Mem[7] = 32'h00832800;
    dut.Mem[8] = 32'hfc000000;
  endtask

  task automatic exp_prog1(input string t);
    exp_reg({t, "_r0"}, 0, 0);
    exp_reg({t, "_r1"}, 1, 10);
    exp_reg({t, "_r2"}, 2, 20);
    exp_reg({t, "_r3"}, 3, 25);
    exp_reg({t, "_r4"}, 4, 30);
    exp_reg({t, "_r5"}, 5, 55);
    exp_reg({t, "_r15"}, 15, 7);
  endtask

  initial begin
    // test 1: basic program, reset state
    begin_test();
    load_prog1();
    exp_prog1("t1");
    #1;
    check("rst_halted", halted, 0);
    check("rst_pc", dut.PC, 0);
    release_rst();
    check("rel_halted", halted, 0);
    run("t1_halt_edge", 13);

    // test 2: back-to-back dependencies
    begin_test();
    dut.Mem[0] = 32'h28010005;
    dut.Mem[1] = 32'h00211000;
    dut.Mem[2] = 32'h00411800;
    dut.Mem[3] = 32'hfc000000;
    exp_reg("t2_r1", 1, 5);
    exp_reg("t2_r2", 2, 10);
    exp_reg("t2_r3", 3, 15);
    release_rst();
    run("t2_halt_edge", 8);

    // test 3: load-use stall plus forwarded store data
    begin_test();
    dut.Mem[100] = 32'd77;
    dut.Mem[0] = 32'h20060064;
    dut.Mem[1] = 32'h00c63800;
    dut.Mem[2] = 32'h24070065;
    dut.Mem[3] = 32'hfc000000;
    exp_reg("t3_r6", 6, 77);
    exp_reg("t3_r7", 7, 154);
    exp_mem("t3_mem101", 101, 154);
    release_rst();
    run("t3_halt_edge", 9);

    // test 4a: BEQZ taken skips two instructions
    begin_test();
    dut.Mem[0] = 32'h28010000;
    dut.Mem[1] = 32'h38200002;
    dut.Mem[2] = 32'h28020063;
    dut.Mem[3] = 32'h28030063;
    dut.Mem[4] = 32'h28040007;
    dut.Mem[5] = 32'hfc000000;
    exp_reg("t4a_r1", 1, 0);
    exp_reg("t4a_r2", 2, 2);
    exp_reg("t4a_r3", 3, 3);
    exp_reg("t4a_r4", 4, 7);
    release_rst();
    run("t4a_halt_edge", 11);

    // test 4b: BNEQZ not taken falls through
    begin_test();
    dut.Mem[0] = 32'h28010000;
    dut.Mem[1] = 32'h34200002;
    dut.Mem[2] = 32'h28020063;
    dut.Mem[3] = 32'h28030063;
    dut.Mem[4] = 32'h28040007;
    dut.Mem[5] = 32'hfc000000;
    exp_reg("t4b_r2", 2, 99);
    exp_reg("t4b_r3", 3, 99);
    exp_reg("t4b_r4", 4, 7);
    release_rst();
    run("t4b_halt_edge", 10);

    // test 5: R0 write ignored, nothing after HLT retires, state frozen
    begin_test();
    dut.Mem[0] = 32'h28000005;
    dut.Mem[1] = 32'hfc000000;
    dut.Mem[2] = 32'h28090001;
    exp_reg("t5_r0", 0, 0);
    exp_reg("t5_r9", 9, 9);
    release_rst();
    run("t5_halt_edge", 6);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk1);
      #1;
      check($sformatf("t5_halted_c%0d", c), halted, 1);
      check($sformatf("t5_pc_c%0d", c), dut.PC, 5);
    end
    check("t5_r9_late", dut.Reg[9], 9);

    // test 6: reset mid-run aborts, rerun gives the same result
    begin_test();
    load_prog1();
    release_rst();
    repeat (6) @(posedge clk1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_pc", dut.PC, 0);
    check("t6_rst_halted", halted, 0);
    @(posedge clk1);
    @(posedge clk1);
    #1;
    check("t6_rst_pc_hold", dut.PC, 0);
    check("t6_rst_halted_hold", halted, 0);
    exp_prog1("t6");
    release_rst();
    run("t6_halt_edge", 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_mips32.md
Name: pipe_mips32

Overview:
- 5-stage in-order pipelined MIPS32-subset processor: IF, ID, EX, MEM, WB.
- Contains a unified word-addressed instruction/data memory and a 32x32 register file.
- Program and data are preloaded through hierarchical access (Mem, Reg).
- Runs from PC 0 after reset until an HLT instruction retires.

Parameters:
- MEM_DEPTH, 1024, words in unified memory; addresses wrap modulo MEM_DEPTH.
- DATA_W, 32, datapath and instruction width.

Ports:
- clk1  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- halted  out  1  high once HLT has retired; mirrors internal HALTED.

Behaviour:
Internal state:
- Mem[0:MEM_DEPTH-1] and Reg[0:31] keep exactly these names; the bench pokes and peeks them hierarchically.
- Neither array is reset.
- Reg[0] always reads 0; writes to R0 are ignored.

Reset:
- PC=0, HALTED=0, TAKEN_BRANCH=0.
- All pipeline latches hold bubbles (valid=0, no writes).
- Reset asserted mid-run aborts all in-flight instructions; Mem and Reg are retained.

Encoding (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended):
- R-type, rd <= rs op rt: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1/0), MUL 000101 (low 32 bits).
- I-type ALU, rt <= rs op imm: ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- LW 001000: rt <= Mem[rs+imm].
- SW 001001: Mem[rs+imm] <= rt.
- BNEQZ 001101 / BEQZ 001110: branch if rs!=0 / rs==0; target = (branch PC+1) + imm.
- HLT 111111.
- Any other opcode is a NOP (no writes).
- All arithmetic is 32-bit wraparound; no overflow trap.

Timing:
- Instruction at address i (no stalls or branches) occupies IF/ID after edge i+1, ID/EX after i+2, EX/MEM after i+3, MEM/WB after i+4.
- It writes Reg at edge i+5.

Hazards:
- Full forwarding EX/MEM->EX and MEM/WB->EX for rs and rt, including SW store data and branch condition.
- Register file is write-before-read: an ID read in the WB cycle sees the new value.
- Load-use: if ID/EX holds LW and the instruction in ID reads its rt, IF and ID hold and one bubble is inserted into EX.
- Branch is resolved in MEM, using condition and target registered in EX/MEM.
- On a taken branch: PC <= target, IF/ID and ID/EX are squashed to bubbles, and the instruction leaving EX is not written into EX/MEM as valid.
- TAKEN_BRANCH pulses high for that cycle.
- Squashed instructions never write Reg or Mem.

Halt:
- When HLT reaches WB, HALTED <= 1 at that edge.
- PC freezes and no younger in-flight instruction writes Reg or Mem.
- State stays frozen until rst.
- The halting program's Reg and Mem results are final at that edge.

Memory:
- Reads are combinational.
- SW writes at the edge leaving MEM.
- A simultaneous fetch of the same address returns the old word.

Decomposition:
- Package mips32_pkg: opcode localparams, instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP), field-slice constants, pipeline-latch struct typedefs.
- One natural sub-module: mips32_alu (op, a, b -> result; combinational).
- Forwarding, stall and flush logic stays in the top.

Test Plan:
1. Preload Reg[k]=k and load this program. Mem[0..8] = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000. Required: R0..R5 = 0,10,20,25,30,55, and halted rises at edge 13 after reset release.
2. Back-to-back dependency, no spacers: ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT. Required: R1=5, R2=10, R3=15.
3. Load-use: Mem[100]=77; LW R6,100(R0); ADD R7,R6,R6; SW R7,101(R0); HLT. Required: R7=154, Mem[101]=154, one stall cycle (halt one edge later than the no-stall count).
4. Branch taken, with Reg preloaded k: ADDI R1,R0,0; BEQZ R1,+2; ADDI R2,R0,99; ADDI R3,R0,99; ADDI R4,R0,7; HLT. Required: R2=2, R3=3 (unchanged), R4=7. Repeat with BNEQZ: R2=99, R3=99.
5. R0 and halt isolation: ADDI R0,R0,5; HLT; ADDI R9,R0,1. Required: R0=0, R9=9 (unchanged), PC frozen, halted stays 1 for 20 further cycles.
6. Assert rst mid-run of test 1 at edge 6 for 2 cycles. Required: halted=0 and PC=0 during reset, then rerun to the same final R0..R5 values.
